spi_byte_master: RTL and testbench

Byte-level SPI master engine that serves the command processor's SPI handshake (`spitx`/`spitxdv`/`spitxready` in, `spirx`/`spirxdv` out) and drives the ADC's SCLK/MOSI while sampling MISO. It runs one full-duplex 8-bit transfer per accepted byte, MSB first. Chip select is not driven here; the command processor owns `spicsadc` and frames multi-byte transactions around this block.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_byte_master_if.sv | 26 ++
 rtl/spi_clk_gen.sv | 64 ++++++
 rtl/spi_byte_master.sv | 126 ++++++++++++
 tb/tb_spi_byte_master.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI byte master.
package spi_pkg;

  localparam int unsigned SPI_CPOL_BIT = 1;
  localparam int unsigned SPI_CPHA_BIT = 0;
  localparam int unsigned SPI_EDGES    = 16;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } spi_state_e;

endpackage

// File: rtl/spi_byte_master_if.sv
// Byte handshake between the command processor (master) and the SPI engine (slave).
interface spi_byte_master_if;

  logic [7:0] spitx;
  logic       spitxdv;
  logic       spitxready;
  logic [7:0] spirx;
  logic       spirxdv;

  modport master (
    output spitx,
    output spitxdv,
    input  spitxready,
    input  spirx,
    input  spirxdv
  );

  modport slave (
    input  spitx,
    input  spitxdv,
    output spitxready,
    output spirx,
    output spirxdv
  );

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-bit counter, SCLK register and edge counter, with one-cycle
// strobes marking the clk edge on which each SCLK transition happens.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLKS_PER_HALF_BIT = 2,
  parameter bit          CPOL              = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic active,
  output logic sclk,
  output logic lead_stb,
  output logic trail_stb,
  output logic done
);

  localparam logic [7:0] HalfTc   = 8'(CLKS_PER_HALF_BIT - 1);
  localparam logic [4:0] LastEdge = 5'(SPI_EDGES - 1);

  logic [7:0] half_cnt_q, half_cnt_d;
  logic [4:0] edge_cnt_q, edge_cnt_d;
  logic       sclk_q, sclk_d;
  logic       tc;

  always_comb begin
    tc        = active && (half_cnt_q == HalfTc);
    // edge_cnt_q is the number of edges already made, so an even count means a leading edge
    lead_stb  = tc && !edge_cnt_q[0];
    trail_stb = tc && edge_cnt_q[0];
    done      = tc && (edge_cnt_q == LastEdge);

    half_cnt_d = half_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    if (start) begin
      half_cnt_d = 8'd0;
      edge_cnt_d = 5'd0;
      sclk_d     = CPOL;
    end else if (tc) begin
      half_cnt_d = 8'd0;
      edge_cnt_d = edge_cnt_q + 5'd1;
      sclk_d     = ~sclk_q;
    end else if (active) begin
      half_cnt_d = half_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      half_cnt_q <= 8'd0;
      edge_cnt_q <= 5'd0;
      sclk_q     <= CPOL;
    end else begin
      half_cnt_q <= half_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_byte_master.sv
// Full-duplex 8-bit SPI master, MSB first, one transfer per accepted byte.
// Build option SPI_LOOPBACK_EN samples the internal MOSI register instead of spi_miso.
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int unsigned CLKS_PER_HALF_BIT = 2,
  parameter int unsigned SPI_MODE          = 0
) (
  input  logic               clk,
  input  logic               rstn,
  spi_byte_master_if.slave   bus,
  output logic               spi_sclk,
  output logic               spi_mosi,
  input  logic               spi_miso
);

  localparam logic [1:0] ModeBits = 2'(SPI_MODE);
  localparam bit         Cpol     = ModeBits[SPI_CPOL_BIT];
  localparam bit         Cpha     = ModeBits[SPI_CPHA_BIT];

  spi_state_e state_q, state_d;

  logic       accept, active;
  logic       lead_stb, trail_stb, done;
  logic       sample_stb, drive_stb, sample_src;
  logic [7:0] rx_shift;

  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       mosi_q, mosi_d;
  logic [7:0] spirx_q, spirx_d;
  logic       spirxdv_q, spirxdv_d;
  logic       ready_q, ready_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.spitxdv) state_d = StShift;
      StShift: if (done)        state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  spi_clk_gen #(
    .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT),
    .CPOL              (Cpol)
  ) u_clk_gen (
    .clk       (clk),
    .rstn      (rstn),
    .start     (accept),
    .active    (active),
    .sclk      (spi_sclk),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .done      (done)
  );

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign sample_src  = mosi_q;
`else
  assign sample_src  = spi_miso;
`endif

  always_comb begin
    accept     = (state_q == StIdle) && bus.spitxdv;
    active     = (state_q == StShift);
    sample_stb = Cpha ? trail_stb : lead_stb;
    drive_stb  = Cpha ? lead_stb : trail_stb;
    rx_shift   = sample_stb ? {rx_q[6:0], sample_src} : rx_q;

    tx_d      = tx_q;
    rx_d      = rx_shift;
    mosi_d    = mosi_q;
    spirx_d   = spirx_q;
    spirxdv_d = 1'b0;
    ready_d   = (state_d == StIdle);

    if (accept) begin
      // CPHA=0 presents bit7 immediately, so the shifter starts one bit ahead
      tx_d   = Cpha ? bus.spitx : {bus.spitx[6:0], 1'b0};
      rx_d   = 8'h00;
      mosi_d = Cpha ? 1'b0 : bus.spitx[7];
    end else if (done) begin
      mosi_d    = 1'b0;
      spirx_d   = rx_shift;
      spirxdv_d = 1'b1;
    end else if (drive_stb) begin
      mosi_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      mosi_q    <= 1'b0;
      spirx_q   <= 8'h00;
      spirxdv_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      mosi_q    <= mosi_d;
      spirx_q   <= spirx_d;
      spirxdv_q <= spirxdv_d;
      ready_q   <= ready_d;
    end
  end

  assign spi_mosi       = mosi_q;
  assign bus.spitxready = ready_q;
  assign bus.spirx      = spirx_q;
  assign bus.spirxdv    = spirxdv_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench: four instances (SPI modes 0..3, H=2) against a timeline model.
module tb_spi_byte_master;

  localparam int H  = 2;
  localparam int NM = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] spitx = 8'h00;
  logic       spitxdv = 1'b0;
  logic [NM-1:0] sclk, mosi, ready, dv;
  logic [NM-1:0] miso = '0;
  logic [7:0] rx [NM];

  always #5 clk = ~clk;

  for (genvar m = 0; m < NM; m++) begin : g_dut
    spi_byte_master_if bus ();
    assign bus.spitx   = spitx;
    assign bus.spitxdv = spitxdv;
    assign ready[m]    = bus.spitxready;
    assign rx[m]       = bus.spirx;
    assign dv[m]       = bus.spirxdv;
    spi_byte_master #(
      .CLKS_PER_HALF_BIT (H),
      .SPI_MODE          (m)
    ) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .bus      (bus),
      .spi_sclk (sclk[m]),
      .spi_mosi (mosi[m]),
      .spi_miso (miso[m])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic cpol_of(input int m);
    return m[1];
  endfunction

  function automatic logic cpha_of(input int m);
    return m[0];
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] tx, input logic [7:0] s);
`ifdef SPI_LOOPBACK_EN
    return tx;
`else
    return s;
`endif
  endfunction

  // Model: a transfer is a window of 16*H cycles after the accept edge
  int         cyc = 0;
  bit         busy = 1'b0;
  int         acc = 0;
  int         done_cyc = -100;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_s = 8'h00;
  logic [7:0] exp_rx = 8'h00;
  logic [7:0] slave_byte = 8'h3C;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      busy     = 1'b0;
      exp_rx   = 8'h00;
      done_cyc = -100;
    end else if (busy) begin
      if (cyc - acc == 16 * H) begin
        busy     = 1'b0;
        exp_rx   = exp_byte(m_tx, m_s);
        done_cyc = cyc;
      end
    end else if (spitxdv) begin
      busy = 1'b1;
      acc  = cyc;
      m_tx = spitx;
      m_s  = slave_byte;
    end
  end

  function automatic int edges_now();
    return busy ? (cyc - acc) / H : 0;
  endfunction

  function automatic logic exp_mosi(input int m, input int e);
    int idx;
    if (!busy) return 1'b0;
    if (!cpha_of(m)) idx = 7 - e / 2;
    else if (e == 0) return 1'b0;
    else idx = 7 - (e - 1) / 2;
    return m_tx[idx];
  endfunction

  // Slave: present the next response bit once the previous one has been sampled
  initial forever begin
    @(negedge clk);
    for (int m = 0; m < NM; m++) begin
      int e, n;
      e = edges_now();
      n = cpha_of(m) ? e / 2 : (e + 1) / 2;
`ifdef SPI_LOOPBACK_EN
      miso[m] = 1'b1;
`else
      miso[m] = (busy && n < 8) ? m_s[7 - n] : 1'b0;
`endif
    end
  end

  logic       prev_sclk0 = 1'b0;
  logic       prev_mosi0 = 1'b0;
  logic [7:0] lead_bits = 8'h00;
  int         tog_cnt = 0;
  int         dv_cnt = 0;
  int         dv_last = 0;
  int         dv_prev = 0;

  initial forever begin
    @(negedge clk);
    for (int m = 0; m < NM; m++) begin
      int e;
      e = edges_now();
      chk("sclk", {31'd0, sclk[m]}, {31'd0, cpol_of(m) ^ e[0]});
      chk("mosi", {31'd0, mosi[m]}, {31'd0, exp_mosi(m, e)});
      chk("ready", {31'd0, ready[m]}, {31'd0, !busy});
      chk("rxdv", {31'd0, dv[m]}, {31'd0, (!busy && cyc == done_cyc)});
      chk("rx", {24'd0, rx[m]}, {24'd0, exp_rx});
    end
    if (sclk[0] !== prev_sclk0) begin
      tog_cnt++;
      if (sclk[0]) lead_bits = {lead_bits[6:0], prev_mosi0};
    end
    prev_sclk0 = sclk[0];
    prev_mosi0 = mosi[0];
    if (dv[0]) begin
      dv_cnt++;
      dv_prev = dv_last;
      dv_last = cyc + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_dv(input int target);
    for (int i = 0; i < 120 && dv_cnt < target; i++) step(1);
  endtask

  int a, dv0, tog0;

  initial begin
    #1 rstn = 1'b0;
    step(1);
    for (int m = 0; m < NM; m++) begin
      chk("rst_sclk", {31'd0, sclk[m]}, {31'd0, cpol_of(m)});
      chk("rst_mosi", {31'd0, mosi[m]}, 32'd0);
      chk("rst_ready", {31'd0, ready[m]}, 32'd1);
      chk("rst_rx", {24'd0, rx[m]}, 32'h00);
    end
    step(2);
    rstn = 1'b1;
    step(2);

    // Single transfer A5 / 3C
    dv0 = dv_cnt; tog0 = tog_cnt; lead_bits = 8'h00;
    spitx = 8'hA5; slave_byte = 8'h3C; a = cyc + 1; spitxdv = 1'b1;
    step(1);
    spitxdv = 1'b0; spitx = 8'h00;
    wait_dv(dv0 + 1);
    chk("t1_dv_count", dv_cnt - dv0, 1);
    chk("t1_latency", dv_last - a, 33);
    chk("t1_mosi_leading", {24'd0, lead_bits}, 32'hA5);
    chk("t1_sclk_edges", tog_cnt - tog0, 16);
    chk("t1_sclk_idle", {31'd0, sclk[0]}, 32'd0);
    for (int m = 0; m < NM; m++) chk("t1_rx_mode", {24'd0, rx[m]}, {24'd0, exp_byte(8'hA5, 8'h3C)});
    step(3);

    // Back-to-back with spitxdv held
    dv0 = dv_cnt;
    spitx = 8'h01; a = cyc + 1; spitxdv = 1'b1;
    step(1);
    spitx = 8'h80;
    step(33);
    spitxdv = 1'b0;
    wait_dv(dv0 + 2);
    chk("b2b_dv_count", dv_cnt - dv0, 2);
    chk("b2b_first_latency", dv_prev - a, 33);
    chk("b2b_gap", dv_last - dv_prev, 33);
    chk("b2b_rx", {24'd0, rx[1]}, {24'd0, exp_byte(8'h80, 8'h3C)});
    step(3);

    // Request during SHIFT is ignored
    dv0 = dv_cnt; lead_bits = 8'h00;
    spitx = 8'hC3; spitxdv = 1'b1;
    step(1);
    spitxdv = 1'b0;
    step(9);
    spitx = 8'hFF; spitxdv = 1'b1;
    step(1);
    spitxdv = 1'b0;
    wait_dv(dv0 + 1);
    step(40);
    chk("ign_dv_count", dv_cnt - dv0, 1);
    chk("ign_mosi_leading", {24'd0, lead_bits}, 32'hC3);
    chk("ign_rx", {24'd0, rx[3]}, {24'd0, exp_byte(8'hC3, 8'h3C)});

    // Asynchronous reset at SCLK edge 7
    dv0 = dv_cnt;
    spitx = 8'h5A; spitxdv = 1'b1;
    step(1);
    spitxdv = 1'b0;
    step(7 * H);
    rstn = 1'b0;
    #1;
    for (int m = 0; m < NM; m++) begin
      chk("arst_sclk", {31'd0, sclk[m]}, {31'd0, cpol_of(m)});
      chk("arst_mosi", {31'd0, mosi[m]}, 32'd0);
      chk("arst_rx", {24'd0, rx[m]}, 32'h00);
      chk("arst_ready", {31'd0, ready[m]}, 32'd1);
    end
    step(3);
    rstn = 1'b1;
    step(2);
    chk("arst_no_dv", dv_cnt - dv0, 0);
    spitx = 8'h96; a = cyc + 1; spitxdv = 1'b1;
    step(1);
    spitxdv = 1'b0;
    wait_dv(dv0 + 1);
    chk("post_rst_latency", dv_last - a, 33);
    chk("post_rst_rx", {24'd0, rx[2]}, {24'd0, exp_byte(8'h96, 8'h3C)});
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
